psr_conf_n: RTL
===============

// Module: psr_conf_n
// PURPOSE
//  N-input confluence buffer, clocked. Merges single-cycle pulses from N
//  channels onto one output pulse line after a fixed pipeline delay.
//  Enforces a minimum separation between merged pulses.
//  MODE 0 flags separation violations. MODE 1 queues colliding pulses and
//  re-times them so no violation reaches the output.
//  Sits at fan-in points of the pulse-level behavioural netlist, replacing
//  chains of 2-input merge cells.
// PARAMETERS
//  N       2   number of input channels (>=2)
//  DELAY   15  input-to-output latency in clk cycles (>=1)
//  T_SEP   10  min cycles between successive merged pulses (>=1)
//  MODE    0   0 = flag violations; 1 = serialise via pending counter
//  PEND_W  4   width of MODE-1 pending counter (max 2**PEND_W-1)
//  CNT_W   16  width of violation counter
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       synchronous active-low reset
//  in         in   N       input pulses, one bit per channel, sampled each edge
//  out        out  1       merged pulse, one cycle wide
//  out_err    out  1       with out: this pulse came from a violation (MODE 0)
//  viol       out  1       one-cycle violation/overflow strobe
//  viol_mask  out  N       channels that were active in the last violating cycle
//  viol_cnt   out  CNT_W   saturating count of violating cycles
//  pend       out  PEND_W  pulses waiting to issue (MODE 1; 0 in MODE 0)
//  overflow   out  1       sticky: a MODE-1 pulse was dropped
// BEHAVIOUR
//  Reset (rst_n=0 at an edge):
//   - out, out_err, viol, viol_mask, viol_cnt, pend, overflow all become 0.
//   - The delay line, pending counter and sep_cnt are cleared.
//   - In-flight pulses are discarded. in is ignored in the reset cycle.
//  k = popcount(in) at each edge.
//  sep_cnt: cycles left in the separation window.
//   - Loaded with T_SEP-1 on every issue; otherwise decrements, floor 0.
//   - Window is open while sep_cnt != 0.
//  Delay line: DELAY-stage shift register of {pulse, err}.
//   - An issue at edge t gives out=1 during the cycle after edge t+DELAY-1.
//   - Latency is exactly DELAY cycles from the sampling edge.
//  MODE 0:
//   - Issue on every edge with k>=1; exactly one pulse regardless of k.
//   - Violation when k>=2 or the window is open.
//   - On violation, registered at the same edge:
//       viol=1 for one cycle, viol_mask=in, viol_cnt+=1 (saturating).
//   - The issued pulse carries err=1 and appears as out=1 with out_err=1.
//   - Violating pulses still reload sep_cnt.
//  MODE 1:
//   - issue = (pend+k>0) && sep_cnt==0. At most one issue per edge.
//   - pend_next = pend + k - issue.
//   - A pulse arriving with pend=0 and a closed window issues at once,
//     with the same latency as MODE 0.
//   - If pend_next > 2**PEND_W-1: saturate pend and set overflow (sticky).
//     Also viol=1, viol_mask=in, viol_cnt+=1. Excess pulses are dropped.
//   - out_err is always 0. Collisions alone are not violations.
//  Simultaneous issue and reset: reset wins.
//  viol_cnt holds at all-ones once saturated.
// TESTING
//  T1 (MODE0, N=2, DELAY=15, T_SEP=10): in=01 at edge 0.
//     -> out=1 at cycle 15, out_err=0, viol never asserts.
//  T2 (MODE0): in=01 at edge 0, in=10 at edge 5.
//     -> viol=1 after edge 5, viol_mask=10, viol_cnt=1.
//     -> out=1 at 15 (err=0) and at 20 (err=1).
//  T3 (MODE0): in=11 at edge 0.
//     -> a single out at cycle 15 with out_err=1; viol_mask=11.
//  T4 (MODE1, N=4): in=1111 at edge 0.
//     -> out at cycles 15, 25, 35, 45; pend reads 3, 2, 1, 0; viol never asserts.
//  T5 (MODE1, PEND_W=2, N=4): in=1111 at edges 0 and 1.
//     -> pend saturates at 3, overflow=1 and viol_cnt=1 after edge 1.
//  T6: in=01 at edge 0, rst_n=0 at edge 5.
//     -> no out at cycle 15; all outputs 0 after edge 5.

Source files
------------

// File: rtl/psr_conf_n.sv
// N-input pulse confluence buffer: merges single-cycle channel pulses onto one
// line after a fixed latency, either flagging or serialising too-close pulses.
module psr_conf_n #(
    parameter int N      = 2,
    parameter int DELAY  = 15,
    parameter int T_SEP  = 10,
    parameter int MODE   = 0,
    parameter int PEND_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      in,
    output logic              out,
    output logic              out_err,
    output logic              viol,
    output logic [N-1:0]      viol_mask,
    output logic [CNT_W-1:0]  viol_cnt,
    output logic [PEND_W-1:0] pend,
    output logic              overflow
);

    localparam int K_W   = $clog2(N + 1);
    localparam int SEP_W = (T_SEP > 1) ? $clog2(T_SEP) : 1;
    localparam int SUM_W = ((PEND_W > K_W) ? PEND_W : K_W) + 1;
    localparam int PMAX  = (1 << PEND_W) - 1;

    function automatic logic [K_W-1:0] popcount(input logic [N-1:0] v);
        logic [K_W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + K_W'(v[i]);
        end
        return c;
    endfunction

    logic [DELAY-1:0]  dlp_q, dlp_d;
    logic [DELAY-1:0]  dle_q, dle_d;
    logic [SEP_W-1:0]  sep_q, sep_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              viol_q, viol_d;
    logic [N-1:0]      mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [K_W-1:0]    k_s;
    logic              sep_open_s;
    logic              issue_s;
    logic              err_s;
    logic              bad_s;
    logic [SUM_W-1:0]  sum_s;
    logic [SUM_W-1:0]  rem_s;

    // Issue decision, pending bookkeeping, separation window and delay line advance
    always_comb begin
        k_s        = popcount(in);
        sep_open_s = (sep_q != '0);
        issue_s    = 1'b0;
        err_s      = 1'b0;
        bad_s      = 1'b0;
        sum_s      = '0;
        rem_s      = '0;
        pend_d     = '0;
        ovf_d      = 1'b0;

        if (MODE == 0) begin
            issue_s = (k_s != '0);
            err_s   = issue_s && ((k_s > K_W'(1)) || sep_open_s);
            bad_s   = err_s;
        end else begin
            sum_s   = SUM_W'(pend_q) + SUM_W'(k_s);
            issue_s = (sum_s != '0) && !sep_open_s;
            rem_s   = sum_s - SUM_W'(issue_s);
            // Anything beyond the counter's range is dropped and reported
            if (rem_s > SUM_W'(PMAX)) begin
                pend_d = PEND_W'(PMAX);
                ovf_d  = 1'b1;
                bad_s  = 1'b1;
            end else begin
                pend_d = rem_s[PEND_W-1:0];
                ovf_d  = ovf_q;
                bad_s  = 1'b0;
            end
        end

        if (issue_s) begin
            sep_d = SEP_W'(T_SEP - 1);
        end else if (sep_open_s) begin
            sep_d = sep_q - SEP_W'(1);
        end else begin
            sep_d = sep_q;
        end

        dlp_d[0] = issue_s;
        dle_d[0] = err_s;
        for (int i = 1; i < DELAY; i++) begin
            dlp_d[i] = dlp_q[i-1];
            dle_d[i] = dle_q[i-1];
        end

        viol_d = bad_s;
        if (bad_s) begin
            mask_d = in;
        end else begin
            mask_d = mask_q;
        end
        if (bad_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset discarding in-flight pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dlp_q  <= '0;
            dle_q  <= '0;
            sep_q  <= '0;
            pend_q <= '0;
            viol_q <= 1'b0;
            mask_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            dlp_q  <= dlp_d;
            dle_q  <= dle_d;
            sep_q  <= sep_d;
            pend_q <= pend_d;
            viol_q <= viol_d;
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out       = dlp_q[DELAY-1];
    assign out_err   = dle_q[DELAY-1];
    assign viol      = viol_q;
    assign viol_mask = mask_q;
    assign viol_cnt  = cnt_q;
    assign pend      = pend_q;
    assign overflow  = ovf_q;

endmodule
